// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register with hazard handling.
//   - forwarding select codes driven on out_fwd_a/out_fwd_b
//   - stall FSM state encoding
//   - default bit positions of the load and reg-write flags in the control bundles
package id_ex_hazard_reg_pkg;

  // Operand source select codes.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // result sitting in EX/MEM
  localparam logic [1:0] FWD_MEMWB = 2'b01;  // result sitting in MEM/WB

  // Stall FSM: StBubble is the cycle right after a stall, in which no new stall may be raised.
  typedef enum logic {
    StRun    = 1'b0,
    StBubble = 1'b1
  } hz_state_e;

  // Default flag positions inside the control bundles.
  localparam int unsigned MEM_READ_BIT_DEF     = 1;
  localparam int unsigned WB_REG_WRITE_BIT_DEF = 0;

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// Bundle of every ID-side and EX-side signal of the ID/EX register.
//   master : the surrounding pipeline; drives in_* and observes out_*
//   slave  : the id_ex_hazard_reg block; observes in_* and drives out_*
// in_*  : ID instruction (valid, flush, control bundles, operands, register fields) plus the
//         EX/MEM and MEM/WB destination info used for forwarding
// out_* : registered EX instruction, combinational stall, forward selects, stall counter
interface id_ex_hazard_reg_if #(
  parameter int unsigned NB_data = 32,
  parameter int unsigned NB_addr = 5,
  parameter int unsigned NB_ex   = 8,
  parameter int unsigned NB_mem  = 3,
  parameter int unsigned NB_wb   = 2,
  parameter int unsigned NB_cnt  = 16
);

  logic               in_valid;
  logic               in_flush;
  logic [NB_ex-1:0]   in_ex;
  logic [NB_mem-1:0]  in_mem;
  logic [NB_wb-1:0]   in_wb;
  logic [NB_data-1:0] in_reg1;
  logic [NB_data-1:0] in_reg2;
  logic [NB_data-1:0] in_inmediato;
  logic [NB_data-1:0] in_branch;
  logic [NB_addr-1:0] in_shamt;
  logic [NB_addr-1:0] in_rs;
  logic [NB_addr-1:0] in_rt;
  logic [NB_addr-1:0] in_rd;
  logic               in_exmem_reg_write;
  logic [NB_addr-1:0] in_exmem_rd;
  logic               in_memwb_reg_write;
  logic [NB_addr-1:0] in_memwb_rd;

  logic               out_valid;
  logic [NB_ex-1:0]   out_ex;
  logic [NB_mem-1:0]  out_mem;
  logic [NB_wb-1:0]   out_wb;
  logic [NB_data-1:0] out_reg1;
  logic [NB_data-1:0] out_reg2;
  logic [NB_data-1:0] out_inmediato;
  logic [NB_data-1:0] out_branch;
  logic [NB_addr-1:0] out_shamt;
  logic [NB_addr-1:0] out_rs;
  logic [NB_addr-1:0] out_rt;
  logic [NB_addr-1:0] out_rd;
  logic               out_stall;
  logic [1:0]         out_fwd_a;
  logic [1:0]         out_fwd_b;
  logic [NB_cnt-1:0]  out_stall_count;

  modport master (
    output in_valid, in_flush, in_ex, in_mem, in_wb, in_reg1, in_reg2, in_inmediato, in_branch,
           in_shamt, in_rs, in_rt, in_rd, in_exmem_reg_write, in_exmem_rd, in_memwb_reg_write,
           in_memwb_rd,
    input  out_valid, out_ex, out_mem, out_wb, out_reg1, out_reg2, out_inmediato, out_branch,
           out_shamt, out_rs, out_rt, out_rd, out_stall, out_fwd_a, out_fwd_b, out_stall_count
  );

  modport slave (
    input  in_valid, in_flush, in_ex, in_mem, in_wb, in_reg1, in_reg2, in_inmediato, in_branch,
           in_shamt, in_rs, in_rt, in_rd, in_exmem_reg_write, in_exmem_rd, in_memwb_reg_write,
           in_memwb_rd,
    output out_valid, out_ex, out_mem, out_wb, out_reg1, out_reg2, out_inmediato, out_branch,
           out_shamt, out_rs, out_rt, out_rd, out_stall, out_fwd_a, out_fwd_b, out_stall_count
  );

endinterface

// File: rtl/id_ex_hazard_reg_forward_unit.sv
// Forwarding select for one EX operand.
//   en              : EX holds a valid instruction and forwarding is enabled
//   src             : source register field of the EX instruction
//   exmem_reg_write : EX/MEM will write a register
//   exmem_rd        : EX/MEM destination register
//   memwb_reg_write : MEM/WB will write a register
//   memwb_rd        : MEM/WB destination register
//   sel             : FWD_RF / FWD_EXMEM / FWD_MEMWB
module id_ex_hazard_reg_forward_unit
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int unsigned NB_addr = 5
) (
  input  logic               en,
  input  logic [NB_addr-1:0] src,
  input  logic               exmem_reg_write,
  input  logic [NB_addr-1:0] exmem_rd,
  input  logic               memwb_reg_write,
  input  logic [NB_addr-1:0] memwb_rd,
  output logic [1:0]         sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      // EX/MEM is the younger result, so it wins over MEM/WB. $zero is never forwarded.
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src)) begin
        sel = FWD_EXMEM;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register of the MIPS pipeline with load-use stall and flush support.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of id_ex_hazard_reg_if
//     in_*  from ID (instruction, flush) and from EX/MEM, MEM/WB (forwarding info)
//     out_* registered EX instruction; out_stall (combinational) holds PC and IF/ID;
//           out_fwd_a/b operand selects; out_stall_count saturating stall counter
// A load in EX whose rt is read by the instruction in ID costs exactly one stall cycle, during
// which a bubble is inserted into EX. A flush or an invalid ID slot also inserts a bubble.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int unsigned NB_data          = 32,
  parameter int unsigned NB_addr          = 5,
  parameter int unsigned NB_ex            = 8,
  parameter int unsigned NB_mem           = 3,
  parameter int unsigned NB_wb            = 2,
  parameter int unsigned MEM_READ_BIT     = MEM_READ_BIT_DEF,
  parameter int unsigned WB_REG_WRITE_BIT = WB_REG_WRITE_BIT_DEF,
  parameter bit          FWD_EN           = 1'b1,
  parameter int unsigned NB_cnt           = 16
) (
  input logic            clk,
  input logic            reset,
  id_ex_hazard_reg_if.slave bus
);

  // Flag positions must fall inside their bundles.
  if (MEM_READ_BIT >= NB_mem) begin : g_bad_mem_read_bit
    $error("MEM_READ_BIT outside the mem bundle");
  end
  if (WB_REG_WRITE_BIT >= NB_wb) begin : g_bad_wb_reg_write_bit
    $error("WB_REG_WRITE_BIT outside the wb bundle");
  end

  hz_state_e state_q;

  logic load_use;
  logic stall;
  logic load_bubble;
  logic fwd_en;

  always_comb begin
    load_use = bus.out_valid & bus.out_mem[MEM_READ_BIT] & (bus.out_rt != '0) &
               ((bus.out_rt == bus.in_rs) | (bus.out_rt == bus.in_rt)) & bus.in_valid;
    // Only one stall per load: the cycle after a stall never stalls again.
    stall       = (state_q == StRun) & load_use & ~bus.in_flush;
    load_bubble = stall | bus.in_flush | ~bus.in_valid;
    fwd_en      = bus.out_valid & FWD_EN;
  end

  assign bus.out_stall = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= StRun;
      bus.out_valid       <= 1'b0;
      bus.out_ex          <= '0;
      bus.out_mem         <= '0;
      bus.out_wb          <= '0;
      bus.out_reg1        <= '0;
      bus.out_reg2        <= '0;
      bus.out_inmediato   <= '0;
      bus.out_branch      <= '0;
      bus.out_shamt       <= '0;
      bus.out_rs          <= '0;
      bus.out_rt          <= '0;
      bus.out_rd          <= '0;
      bus.out_stall_count <= '0;
    end else begin
      state_q <= stall ? StBubble : StRun;

      // A bubble only kills the controls; datapath fields are captured regardless.
      bus.out_valid <= ~load_bubble;
      bus.out_ex    <= load_bubble ? '0 : bus.in_ex;
      bus.out_mem   <= load_bubble ? '0 : bus.in_mem;
      bus.out_wb    <= load_bubble ? '0 : bus.in_wb;

      bus.out_reg1      <= bus.in_reg1;
      bus.out_reg2      <= bus.in_reg2;
      bus.out_inmediato <= bus.in_inmediato;
      bus.out_branch    <= bus.in_branch;
      bus.out_shamt     <= bus.in_shamt;
      bus.out_rs        <= bus.in_rs;
      bus.out_rt        <= bus.in_rt;
      bus.out_rd        <= bus.in_rd;

      if (stall && (bus.out_stall_count != '1)) begin
        bus.out_stall_count <= bus.out_stall_count + NB_cnt'(1);
      end
    end
  end

  id_ex_hazard_reg_forward_unit #(
    .NB_addr (NB_addr)
  ) u_fwd_a (
    .en              (fwd_en),
    .src             (bus.out_rs),
    .exmem_reg_write (bus.in_exmem_reg_write),
    .exmem_rd        (bus.in_exmem_rd),
    .memwb_reg_write (bus.in_memwb_reg_write),
    .memwb_rd        (bus.in_memwb_rd),
    .sel             (bus.out_fwd_a)
  );

  id_ex_hazard_reg_forward_unit #(
    .NB_addr (NB_addr)
  ) u_fwd_b (
    .en              (fwd_en),
    .src             (bus.out_rt),
    .exmem_reg_write (bus.in_exmem_reg_write),
    .exmem_rd        (bus.in_exmem_rd),
    .memwb_reg_write (bus.in_memwb_reg_write),
    .memwb_rd        (bus.in_memwb_rd),
    .sel             (bus.out_fwd_b)
  );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a behavioural model of the EX-stage contents.
module tb_id_ex_hazard_reg;

  localparam int unsigned NB_data = 32;
  localparam int unsigned NB_addr = 5;
  localparam int unsigned NB_ex   = 8;
  localparam int unsigned NB_mem  = 3;
  localparam int unsigned NB_wb   = 2;
  localparam int unsigned NB_cnt  = 4;
  localparam int          CntMax  = (1 << NB_cnt) - 1;

  logic clk;
  logic reset;

  id_ex_hazard_reg_if #(
    .NB_data (NB_data),
    .NB_addr (NB_addr),
    .NB_ex   (NB_ex),
    .NB_mem  (NB_mem),
    .NB_wb   (NB_wb),
    .NB_cnt  (NB_cnt)
  ) bus ();

  id_ex_hazard_reg #(
    .NB_data (NB_data),
    .NB_addr (NB_addr),
    .NB_ex   (NB_ex),
    .NB_mem  (NB_mem),
    .NB_wb   (NB_wb),
    .NB_cnt  (NB_cnt)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model of what EX must hold.
  bit                 m_valid;
  logic [NB_ex-1:0]   m_ex;
  logic [NB_mem-1:0]  m_mem;
  logic [NB_wb-1:0]   m_wb;
  logic [NB_data-1:0] m_reg1, m_reg2, m_imm, m_branch;
  logic [NB_addr-1:0] m_shamt, m_rs, m_rt, m_rd;
  bit                 m_stalled_last;
  int                 m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_valid = 1'b0; m_ex = '0; m_mem = '0; m_wb = '0;
    m_reg1 = '0; m_reg2 = '0; m_imm = '0; m_branch = '0;
    m_shamt = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_stalled_last = 1'b0; m_count = 0;
  endfunction

  // A load in EX feeding the ID instruction stalls once, unless flushed.
  function automatic bit exp_stall();
    bit dep;
    dep = m_valid && m_mem[1] && (m_rt != 0) && bus.in_valid &&
          ((m_rt == bus.in_rs) || (m_rt == bus.in_rt));
    return dep && !bus.in_flush && !m_stalled_last;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [NB_addr-1:0] src);
    if (!m_valid) return 2'b00;
    if (bus.in_exmem_reg_write && bus.in_exmem_rd != 0 && bus.in_exmem_rd == src) return 2'b10;
    if (bus.in_memwb_reg_write && bus.in_memwb_rd != 0 && bus.in_memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_edge();
    bit s, kill;
    s    = exp_stall();
    kill = s || bus.in_flush || !bus.in_valid;
    m_valid  = !kill;
    m_ex     = kill ? '0 : bus.in_ex;
    m_mem    = kill ? '0 : bus.in_mem;
    m_wb     = kill ? '0 : bus.in_wb;
    m_reg1   = bus.in_reg1;
    m_reg2   = bus.in_reg2;
    m_imm    = bus.in_inmediato;
    m_branch = bus.in_branch;
    m_shamt  = bus.in_shamt;
    m_rs     = bus.in_rs;
    m_rt     = bus.in_rt;
    m_rd     = bus.in_rd;
    m_stalled_last = s;
    if (s && m_count < CntMax) m_count++;
  endfunction

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("valid", 64'(bus.out_valid), 64'(m_valid));
      chk("ex", 64'(bus.out_ex), 64'(m_ex));
      chk("mem", 64'(bus.out_mem), 64'(m_mem));
      chk("wb", 64'(bus.out_wb), 64'(m_wb));
      chk("reg1", 64'(bus.out_reg1), 64'(m_reg1));
      chk("reg2", 64'(bus.out_reg2), 64'(m_reg2));
      chk("imm", 64'(bus.out_inmediato), 64'(m_imm));
      chk("branch", 64'(bus.out_branch), 64'(m_branch));
      chk("shamt", 64'(bus.out_shamt), 64'(m_shamt));
      chk("rs", 64'(bus.out_rs), 64'(m_rs));
      chk("rt", 64'(bus.out_rt), 64'(m_rt));
      chk("rd", 64'(bus.out_rd), 64'(m_rd));
      chk("stall", 64'(bus.out_stall), 64'(exp_stall()));
      chk("fwd_a", 64'(bus.out_fwd_a), 64'(exp_fwd(m_rs)));
      chk("fwd_b", 64'(bus.out_fwd_b), 64'(exp_fwd(m_rt)));
      chk("stall_count", 64'(bus.out_stall_count), 64'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit f, input logic [7:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    bus.in_valid     = v;
    bus.in_flush     = f;
    bus.in_ex        = ex;
    bus.in_mem       = mem;
    bus.in_wb        = wb;
    bus.in_rs        = rs;
    bus.in_rt        = rt;
    bus.in_rd        = rd;
    bus.in_reg1      = $urandom;
    bus.in_reg2      = $urandom;
    bus.in_inmediato = $urandom;
    bus.in_branch    = $urandom;
    bus.in_shamt     = 5'($urandom_range(0, 31));
  endtask

  task automatic fwd_src(input bit ew, input logic [4:0] erd, input bit mw,
                         input logic [4:0] mrd);
    bus.in_exmem_reg_write = ew;
    bus.in_exmem_rd        = erd;
    bus.in_memwb_reg_write = mw;
    bus.in_memwb_rd        = mrd;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
    fwd_src(1'b0, 5'd0, 1'b0, 5'd0);
    model_clear();

    // Reset state.
    #4;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.out_stall_count), 64'd0);
    chk("rst_ex", 64'(bus.out_ex), 64'd0);
    chk("rst_reg1", 64'(bus.out_reg1), 64'd0);
    chk("rst_stall", 64'(bus.out_stall), 64'd0);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // First instruction appears after one edge.
    drive(1'b1, 1'b0, 8'h21, 3'b000, 2'b01, 5'd2, 5'd3, 5'd4);
    step();
    chk("first_valid", 64'(bus.out_valid), 64'd1);
    chk("first_rd", 64'(bus.out_rd), 64'd4);
    chk("first_ex", 64'(bus.out_ex), 64'h21);

    // lw $1 then add using $1: one stall, one bubble, then the add.
    drive(1'b1, 1'b0, 8'h0A, 3'b010, 2'b11, 5'd0, 5'd1, 5'd0);
    step();
    drive(1'b1, 1'b0, 8'h21, 3'b000, 2'b01, 5'd1, 5'd2, 5'd5);
    #1 chk("lu_stall", 64'(bus.out_stall), 64'd1);
    step();
    chk("lu_bubble_valid", 64'(bus.out_valid), 64'd0);
    chk("lu_bubble_ex", 64'(bus.out_ex), 64'd0);
    chk("lu_no_second_stall", 64'(bus.out_stall), 64'd0);
    step();
    chk("lu_add_valid", 64'(bus.out_valid), 64'd1);
    chk("lu_add_rd", 64'(bus.out_rd), 64'd5);
    chk("lu_count", 64'(bus.out_stall_count), 64'd1);

    // Load writing $zero never stalls.
    drive(1'b1, 1'b0, 8'h0A, 3'b010, 2'b11, 5'd0, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 8'h21, 3'b000, 2'b01, 5'd0, 5'd0, 5'd6);
    #1 chk("zero_no_stall", 64'(bus.out_stall), 64'd0);
    step();
    chk("zero_count", 64'(bus.out_stall_count), 64'd1);

    // Forwarding priority.
    drive(1'b1, 1'b0, 8'h21, 3'b000, 2'b01, 5'd3, 5'd6, 5'd7);
    step();
    fwd_src(1'b1, 5'd3, 1'b1, 5'd3);
    #1 chk("fwd_exmem", 64'(bus.out_fwd_a), 64'b10);
    chk("fwd_b_rf", 64'(bus.out_fwd_b), 64'b00);
    fwd_src(1'b0, 5'd3, 1'b1, 5'd3);
    #1 chk("fwd_memwb", 64'(bus.out_fwd_a), 64'b01);
    fwd_src(1'b0, 5'd3, 1'b1, 5'd0);
    #1 chk("fwd_rf", 64'(bus.out_fwd_a), 64'b00);
    step();
    fwd_src(1'b0, 5'd0, 1'b0, 5'd0);

    // Flush wins over load-use.
    drive(1'b1, 1'b0, 8'h0A, 3'b010, 2'b11, 5'd0, 5'd7, 5'd0);
    step();
    drive(1'b1, 1'b1, 8'hFF, 3'b010, 2'b11, 5'd7, 5'd7, 5'd9);
    #1 chk("flush_no_stall", 64'(bus.out_stall), 64'd0);
    step();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ex", 64'(bus.out_ex), 64'd0);
    chk("flush_mem", 64'(bus.out_mem), 64'd0);

    // Chained dependent loads: a stall every other cycle, counter must saturate.
    drive(1'b1, 1'b0, 8'h33, 3'b010, 2'b11, 5'd5, 5'd5, 5'd5);
    repeat (40) step();
    chk("sat_count", 64'(bus.out_stall_count), 64'(CntMax));
    if (!exp_stall()) step();
    chk("mid_stall", 64'(bus.out_stall), 64'd1);

    // Async reset in the middle of a stall cycle.
    #1 reset = 1'b0;
    #1;
    model_clear();
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_count", 64'(bus.out_stall_count), 64'd0);
    chk("arst_ex", 64'(bus.out_ex), 64'd0);
    chk("arst_stall", 64'(bus.out_stall), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // Random traffic; small register range to make hazards and forwards frequent.
    repeat (500) begin
      drive(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10), 8'($urandom),
            3'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)));
      fwd_src(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
              5'($urandom_range(0, 3)));
      step();
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
